aes_key_expand_seq: RTL and testbench

- Sequential AES key-schedule engine that produces one round key per handshake beat, from round 0 (the cipher key) to round NR.
- Generalises the combinational RotWord stage: adds a parametrised byte-rotation amount, round count, an iterative Rcon generator and a valid/ready output stream.
- Sits between the key register and the round datapath of the iterative AES core.

---
 rtl/aes_pkg.sv | 48 ++++
 rtl/aes_sub_word.sv | 18 +
 rtl/aes_key_expand_seq.sv | 169 ++++++++++++++++
 tb/tb_aes_key_expand_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types, constants and helpers for the sequential AES key-schedule engine.
//   word_t / block_t : 32-bit key word and 128-bit key block (w0 in the MSBs).
//   state_e          : expansion controller states.
//   RCON_INIT        : round-constant value for the first generated round key.
//   xtime()          : GF(2^8) multiply-by-two, steps Rcon from round to round.
//   sbox()           : forward AES S-box lookup.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StFin
  } state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Forward S-box; entry 0 sits in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box to each of the four bytes of a 32-bit word.
//   word_i : input word
//   word_o : substituted word (purely combinational)
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t word_i,
  output word_t word_o
);

  always_comb begin
    word_o = '0;
    for (int i = 0; i < 4; i++) begin
      word_o[8*i +: 8] = sbox(word_i[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES key-schedule engine. Emits round keys 0..NR one per valid/ready beat,
// starting with the cipher key itself, then pulses done for one cycle.
//
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   start               : begin an expansion (honoured only when idle)
//   key_in              : cipher key, sampled on the accepting edge only
//   busy                : expansion in progress
//   rk_valid / rk_ready : round-key stream handshake
//   rk_out / rk_index   : current round key and its round number
//   done                : one-cycle pulse after the last round key is taken
//   rd_addr / rd_data   : round-key store read port (1-cycle latency)
//
// Build option: define AES_KEY_EXPAND_RK_RAM_EN to keep every emitted round key in an
// internal store readable through rd_addr/rd_data. Without it rd_data is tied to 0.
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int unsigned NR        = 10,
  parameter int unsigned ROT_BYTES = 1,
  parameter int unsigned IDXW      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [127:0]    key_in,
  output logic            busy,
  output logic            rk_valid,
  input  logic            rk_ready,
  output logic [127:0]    rk_out,
  output logic [IDXW-1:0] rk_index,
  output logic            done,
  input  logic [IDXW-1:0] rd_addr,
  output logic [127:0]    rd_data
);

  localparam int unsigned RotBits = 8 * ROT_BYTES;

  state_e          state_q, state_d;
  block_t          rk_q, rk_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [7:0]      rcon_q, rcon_d;

  logic accept;
  logic last;
  logic launch;

  assign accept = (state_q == StEmit) && rk_ready;
  assign last   = (idx_q == IDXW'(NR));
  assign launch = (state_q == StIdle) && start;

  // Next round key from the current one.
  word_t w0, w1, w2, w3;
  word_t rot_w3, sub_w3, t_word;
  word_t n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk_q;

  if (ROT_BYTES == 0) begin : g_no_rot
    assign rot_w3 = w3;
  end else begin : g_rot
    assign rot_w3 = {w3[31-RotBits:0], w3[31:32-RotBits]};
  end

  aes_sub_word u_sub_word (
    .word_i (rot_w3),
    .word_o (sub_w3)
  );

  assign t_word = sub_w3 ^ {rcon_q, 24'h0};
  assign n0     = w0 ^ t_word;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StEmit;
      StEmit: if (accept && last) state_d = StFin;
      StFin:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy     = 1'b0;
    rk_valid = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: ;
      StEmit: begin
        busy     = 1'b1;
        rk_valid = 1'b1;
      end
      StFin:  done = 1'b1;
      default: ;
    endcase
  end

  // Key/index/Rcon datapath.
  always_comb begin
    rk_d   = rk_q;
    idx_d  = idx_q;
    rcon_d = rcon_q;
    if (launch) begin
      rk_d   = key_in;
      idx_d  = '0;
      rcon_d = RCON_INIT;
    end else if (accept && !last) begin
      rk_d   = {n0, n1, n2, n3};
      idx_d  = idx_q + 1'b1;
      rcon_d = xtime(rcon_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_q   <= '0;
      idx_q  <= '0;
      rcon_q <= RCON_INIT;
    end else begin
      rk_q   <= rk_d;
      idx_q  <= idx_d;
      rcon_q <= rcon_d;
    end
  end

  assign rk_out   = rk_q;
  assign rk_index = idx_q;

`ifdef AES_KEY_EXPAND_RK_RAM_EN
  block_t ram_q [NR+1];
  block_t rd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= int'(NR); i++) begin
        ram_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (accept) begin
        ram_q[idx_q] <= rk_q;
      end
      // Out-of-range addresses read as zero rather than aliasing.
      rd_data_q <= (rd_addr <= IDXW'(NR)) ? ram_q[rd_addr] : '0;
    end
  end

  assign rd_data = rd_data_q;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench for aes_key_expand_seq: FIPS-197 vectors from a table, back-pressure,
// ignored start, mid-run reset and random keys, all against a reference key schedule whose
// S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_expand_seq;

  localparam int NR   = 10;
  localparam int ROT  = 1;
  localparam int IDXW = 4;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [127:0]    key_in;
  logic            busy;
  logic            rk_valid;
  logic            rk_ready;
  logic [127:0]    rk_out;
  logic [IDXW-1:0] rk_index;
  logic            done;
  logic [IDXW-1:0] rd_addr;
  logic [127:0]    rd_data;

  aes_key_expand_seq #(
    .NR        (NR),
    .ROT_BYTES (ROT),
    .IDXW      (IDXW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_index (rk_index),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb     [256];
  logic [127:0] ref_rk [0:NR];
  logic [127:0] got    [0:NR];

  typedef struct {
    logic [127:0] key;
    logic [127:0] k1;
    logic [127:0] k10;
  } vec_t;

  vec_t vecs [2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256 && b != 0; x++) begin
        if (gf_mul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      end
      sb[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Textbook word-recursive key expansion.
  task automatic build_ref(input logic [127:0] key);
    logic [31:0] w [0:4*NR+3];
    logic [31:0] temp;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4 * (NR + 1); i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        for (int r = 0; r < ROT; r++) temp = {temp[23:0], temp[31:24]};
        temp = {sb[temp[31:24]], sb[temp[23:16]], sb[temp[15:8]], sb[temp[7:0]]};
        temp = temp ^ {rcon, 24'h0};
        rcon = gf_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int k = 0; k <= NR; k++) ref_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 128'(busy), 128'h0);
    check({tag, "_rk_valid"}, 128'(rk_valid), 128'h0);
    check({tag, "_rk_out"}, rk_out, 128'h0);
    check({tag, "_rk_index"}, 128'(rk_index), 128'h0);
    check({tag, "_done"}, 128'(done), 128'h0);
    check({tag, "_rd_data"}, rd_data, 128'h0);
  endtask

  // Runs one expansion. start_at >= 0 pulses a stray start (key 0) at that index;
  // abort_at >= 0 asserts reset when that index is on the bus.
  task automatic run_expand(input logic [127:0] key, input bit rnd, input int start_at,
                            input int abort_at);
    int           exp_idx;
    int           cycles;
    int           valid_cycles;
    logic [127:0] prev;
    bit           stalled;
    bit           aborted;
    build_ref(key);
    @(negedge clk);
    start    = 1'b1;
    key_in   = key;
    rk_ready = 1'b0;
    @(negedge clk);
    start        = 1'b0;
    key_in       = {$urandom, $urandom, $urandom, $urandom};
    exp_idx      = 0;
    cycles       = 0;
    valid_cycles = 0;
    stalled      = 1'b0;
    aborted      = 1'b0;
    prev         = '0;
    while (exp_idx <= NR && cycles < 400 && !aborted) begin
      start = 1'b0;
      if (exp_idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        aborted = 1'b1;
      end else begin
        check("rk_valid", 128'(rk_valid), 128'h1);
        check("rk_index", 128'(rk_index), 128'(exp_idx));
        check("rk_out", rk_out, ref_rk[exp_idx]);
        if (stalled) check("stall_hold", rk_out, prev);
        got[exp_idx] = rk_out;
        prev         = rk_out;
        valid_cycles++;
        if (exp_idx == start_at && !stalled) begin
          start  = 1'b1;
          key_in = '0;
        end
        rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        stalled  = !rk_ready;
        if (rk_ready) exp_idx++;
        @(negedge clk);
        cycles++;
      end
    end
    start    = 1'b0;
    rk_ready = 1'b0;
    if (aborted) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("abort_no_done", 128'(done), 128'h0);
      end
      rst_n = 1'b1;
    end else if (exp_idx <= NR) begin
      check("stream_timeout", 128'(exp_idx), 128'(NR + 1));
    end else begin
      check("done_pulse", 128'(done), 128'h1);
      check("fin_valid", 128'(rk_valid), 128'h0);
      check("fin_busy", 128'(busy), 128'h0);
      if (!rnd) check("valid_run_len", 128'(valid_cycles), 128'(NR + 1));
      @(negedge clk);
      check("done_drop", 128'(done), 128'h0);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b0;
    rd_addr  = '0;
    build_sbox();

    vecs[0].key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vecs[0].k1  = 128'ha0fafe1788542cb123a339392a6c7605;
    vecs[0].k10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    vecs[1].key = 128'h0;
    vecs[1].k1  = 128'h62636363626363636263636362636363;
    vecs[1].k10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    #23;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Known-answer vectors with rk_ready held high.
    for (int v = 0; v < 2; v++) begin
      run_expand(vecs[v].key, 1'b0, -1, -1);
      check("vec_idx0", got[0], vecs[v].key);
      check("vec_idx1", got[1], vecs[v].k1);
      check("vec_idx10", got[NR], vecs[v].k10);
    end

    // Random back-pressure on the FIPS key.
    run_expand(vecs[0].key, 1'b1, -1, -1);
    check("bp_idx10", got[NR], vecs[0].k10);

`ifdef AES_KEY_EXPAND_RK_RAM_EN
    for (int a = 0; a <= NR + 1; a++) begin
      @(negedge clk);
      rd_addr = IDXW'(a);
      @(negedge clk);
      check("ram_read", rd_data, (a <= NR) ? ref_rk[a] : 128'h0);
    end
`else
    @(negedge clk);
    rd_addr = IDXW'(NR);
    @(negedge clk);
    check("ram_absent", rd_data, 128'h0);
`endif

    // Stray start while busy must be ignored.
    run_expand(vecs[0].key, 1'b0, 3, -1);
    check("busy_start_idx10", got[NR], vecs[0].k10);

    // Reset mid-run, then a clean restart.
    run_expand(vecs[0].key, 1'b0, -1, 5);
    run_expand(vecs[0].key, 1'b0, -1, -1);
    check("restart_idx1", got[1], vecs[0].k1);

    // Random keys with random back-pressure.
    for (int r = 0; r < 4; r++) begin
      run_expand({$urandom, $urandom, $urandom, $urandom}, 1'b1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
